// File: rtl/keytake_pkg.sv
// Shared types and constants for the key-take record/playback sequencer.
package keytake_pkg;

    // Default widths of one stored event: {keys, dur}.
    localparam int unsigned ENTRY_KEY_W = 4;
    localparam int unsigned ENTRY_DUR_W = 26;
    localparam int unsigned ENTRY_W     = ENTRY_KEY_W + ENTRY_DUR_W;

    // Longest single event: 1 s at 50 MHz.
    localparam int unsigned MAX_DUR_DEF = 49_999_999;

    // Encodings presented on the mode output.
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_REC  = 2'b01;
    localparam logic [1:0] MODE_PLAY = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRec,
        StPfetch,
        StPwait,
        StPlay
    } state_e;

    // Packs one event into the RAM word layout.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [ENTRY_KEY_W-1:0] keys,
        input logic [ENTRY_DUR_W-1:0] dur
    );
        return {keys, dur};
    endfunction

    // Mode reported for a given sequencer state; fetch/wait already count as playing.
    function automatic logic [1:0] mode_of(input state_e st);
        logic [1:0] m;
        case (st)
            StRec:                     m = MODE_REC;
            StPfetch, StPwait, StPlay: m = MODE_PLAY;
            default:                   m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/keytake_event_counter.sv
// Event duration counter: counts up while recording (saturating at MAX_DUR)
// and counts down the hold time while replaying.
module keytake_event_counter
    import keytake_pkg::*;
#(
    parameter int unsigned DUR_W   = ENTRY_DUR_W,
    parameter int unsigned MAX_DUR = MAX_DUR_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [DUR_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [DUR_W-1:0] o_count,
    output logic             o_at_max,
    output logic             o_is_one
);

    localparam logic [DUR_W-1:0] MAX_VAL = DUR_W'(MAX_DUR);
    localparam logic [DUR_W-1:0] ONE_VAL = DUR_W'(1);

    logic [DUR_W-1:0] r_count;

    // Load has priority; increment saturates at MAX_DUR, decrement stops at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_VAL);
    assign o_is_one = (r_count == ONE_VAL);

endmodule

// File: rtl/keytake_sequencer.sv
// Key-take sequencer: records the key bus as run-length events into an external
// single-port synchronous RAM and replays them cycle-exact onto the voice input.
module keytake_sequencer
    import keytake_pkg::*;
#(
    parameter int unsigned KEY_W   = ENTRY_KEY_W,
    parameter int unsigned DUR_W   = ENTRY_DUR_W,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 30,
    parameter int unsigned MAX_DUR = MAX_DUR_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rec_start,
    input  logic                   i_play_start,
    input  logic                   i_stop,
    input  logic [KEY_W-1:0]       i_keys,
    output logic [KEY_W-1:0]       o_keys_out,
    output logic [1:0]             o_mode,
    output logic [ADDR_W:0]        o_take_len,
    output logic [ADDR_W-1:0]      o_ram_addr,
    output logic                   o_ram_wren,
    output logic [KEY_W+DUR_W-1:0] o_ram_wdata,
    input  logic [KEY_W+DUR_W-1:0] i_ram_rdata
);

    localparam int unsigned        ENT_W     = KEY_W + DUR_W;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DUR_W-1:0]   DUR_ONE   = DUR_W'(1);

    // Sequencer state and bookkeeping registers.
    state_e            r_state;
    logic [1:0]        r_mode;
    logic [KEY_W-1:0]  r_cur_keys;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_take_len;
    logic [ADDR_W-1:0] r_rptr;
    logic [KEY_W-1:0]  r_play_keys;
    logic [ENT_W-1:0]  r_next_entry;
    logic              r_fresh;

    // Next-state and control wires.
    state_e            w_state_d;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_wren;
    logic [ENT_W-1:0]  w_ram_wdata;
    logic              w_rec_enter;
    logic              w_commit;
    logic              w_play_enter;
    logic              w_play_load;
    logic              w_play_adv;
    logic [ENT_W-1:0]  w_load_entry;
    logic [ENT_W-1:0]  w_next_entry;
    logic [ADDR_W-1:0] w_rptr_p1;
    logic [ADDR_W-1:0] w_rptr_p2;
    logic              w_more;

    // Shared duration/hold counter wires.
    logic              w_cnt_load;
    logic [DUR_W-1:0]  w_cnt_val;
    logic              w_cnt_inc;
    logic              w_cnt_dec;
    logic [DUR_W-1:0]  w_count;
    logic              w_cnt_at_max;
    logic              w_cnt_is_one;

    // Recording and playback never overlap, so one counter serves both.
    keytake_event_counter #(
        .DUR_W   (DUR_W),
        .MAX_DUR (MAX_DUR)
    ) u_event_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_inc      (w_cnt_inc),
        .i_dec      (w_cnt_dec),
        .o_count    (w_count),
        .o_at_max   (w_cnt_at_max),
        .o_is_one   (w_cnt_is_one)
    );

    // RAM q is only valid in the cycle right after a load; later it is held in r_next_entry.
    assign w_next_entry = r_fresh ? i_ram_rdata : r_next_entry;
    assign w_rptr_p1    = r_rptr + 1'b1;
    assign w_rptr_p2    = r_rptr + ADDR_W'(2);
    assign w_more       = (({1'b0, r_rptr} + 1'b1) < r_take_len);

    // Next-state decode plus RAM port and counter control.
    always_comb begin
        w_state_d    = r_state;
        w_ram_addr   = '0;
        w_ram_wren   = 1'b0;
        w_ram_wdata  = '0;
        w_rec_enter  = 1'b0;
        w_commit     = 1'b0;
        w_play_enter = 1'b0;
        w_play_load  = 1'b0;
        w_play_adv   = 1'b0;
        w_load_entry = i_ram_rdata;
        w_cnt_load   = 1'b0;
        w_cnt_val    = DUR_ONE;
        w_cnt_inc    = 1'b0;
        w_cnt_dec    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_rec_start) begin
                    w_state_d   = StRec;
                    w_rec_enter = 1'b1;
                    w_cnt_load  = 1'b1;
                end else if (i_play_start && (r_take_len != '0)) begin
                    w_state_d    = StPfetch;
                    w_play_enter = 1'b1;
                end
            end

            StRec: begin
                w_ram_addr = r_wptr;
                if ((i_keys != r_cur_keys) || w_cnt_at_max || i_stop) begin
                    // Close the running event; this cycle becomes dur 1 of the next one.
                    w_commit    = 1'b1;
                    w_ram_wren  = 1'b1;
                    w_ram_wdata = {r_cur_keys, w_count};
                    w_cnt_load  = 1'b1;
                    if (i_stop || (r_wptr == LAST_ADDR)) begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            StPfetch: begin
                w_ram_addr = '0;
                w_state_d  = i_stop ? StIdle : StPwait;
            end

            StPwait: begin
                w_ram_addr = w_rptr_p1;
                if (i_stop) begin
                    w_state_d = StIdle;
                end else begin
                    w_play_load = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = i_ram_rdata[DUR_W-1:0];
                    w_state_d   = StPlay;
                end
            end

            StPlay: begin
                w_ram_addr   = w_rptr_p1;
                w_load_entry = w_next_entry;
                if (i_stop) begin
                    w_state_d = StIdle;
                end else if (w_cnt_is_one) begin
                    if (w_more) begin
                        // Advance to the next event and prefetch the one after it.
                        w_play_load = 1'b1;
                        w_play_adv  = 1'b1;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = w_next_entry[DUR_W-1:0];
                        w_ram_addr  = w_rptr_p2;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register; mode is registered from the next state so it tracks the state exactly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_mode  <= MODE_IDLE;
        end else begin
            r_state <= w_state_d;
            r_mode  <= mode_of(w_state_d);
        end
    end

    // Recording bookkeeping: current key value, write pointer and take length.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cur_keys <= '0;
            r_wptr     <= '0;
            r_take_len <= '0;
        end else if (w_rec_enter) begin
            r_cur_keys <= i_keys;
            r_wptr     <= '0;
            r_take_len <= '0;
        end else if (w_commit) begin
            r_cur_keys <= i_keys;
            r_wptr     <= r_wptr + 1'b1;
            r_take_len <= r_take_len + 1'b1;
        end
    end

    // Playback bookkeeping: read pointer, replayed keys and prefetched entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rptr       <= '0;
            r_play_keys  <= '0;
            r_next_entry <= '0;
            r_fresh      <= 1'b0;
        end else begin
            if (w_play_enter) begin
                r_rptr <= '0;
            end else if (w_play_adv) begin
                r_rptr <= w_rptr_p1;
            end
            if (w_play_load) begin
                r_play_keys <= w_load_entry[ENT_W-1 -: KEY_W];
            end
            if (r_fresh) begin
                r_next_entry <= i_ram_rdata;
            end
            r_fresh <= w_play_load;
        end
    end

    assign o_keys_out  = (r_state == StPlay) ? r_play_keys : i_keys;
    assign o_mode      = r_mode;
    assign o_take_len  = r_take_len;
    assign o_ram_addr  = w_ram_addr;
    assign o_ram_wren  = w_ram_wren;
    assign o_ram_wdata = w_ram_wdata;

endmodule

// File: tb/tb_keytake_sequencer.sv
// Self-checking bench for keytake_sequencer with a behavioural RAM and event model.
module tb_keytake_sequencer;
    import keytake_pkg::*;

    localparam int KW    = 4;
    localparam int DW    = 26;
    localparam int AW    = 5;
    localparam int DEPTH = 30;
    localparam int MAXD  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              rec_start;
    logic              play_start;
    logic              stop;
    logic [KW-1:0]     keys;
    logic [KW-1:0]     keys_out;
    logic [1:0]        mode;
    logic [AW:0]       take_len;
    logic [AW-1:0]     ram_addr;
    logic              ram_wren;
    logic [KW+DW-1:0]  ram_wdata;
    logic [KW+DW-1:0]  ram_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_cnt     = 0;

    logic [KW+DW-1:0] mem [0:(1<<AW)-1];

    int               waddr[$];
    logic [KW+DW-1:0] wdat[$];
    int               wcyc[$];
    int               rec_seq[$];
    logic [KW+DW-1:0] exp_ent[$];
    int               exp_cyc[$];
    logic [KW-1:0]    exp_play[$];

    always #5 clk = ~clk;

    keytake_sequencer #(
        .KEY_W   (KW),
        .DUR_W   (DW),
        .ADDR_W  (AW),
        .DEPTH   (DEPTH),
        .MAX_DUR (MAXD)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rec_start  (rec_start),
        .i_play_start (play_start),
        .i_stop       (stop),
        .i_keys       (keys),
        .o_keys_out   (keys_out),
        .o_mode       (mode),
        .o_take_len   (take_len),
        .o_ram_addr   (ram_addr),
        .o_ram_wren   (ram_wren),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    // Single-port synchronous RAM: q valid one cycle after the address.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Write log, sampled mid-cycle while DUT outputs are stable.
    always @(negedge clk) begin
        if (ram_wren) begin
            waddr.push_back(int'(ram_addr));
            wdat.push_back(ram_wdata);
            wcyc.push_back(cyc_cnt);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Event model: split the sample stream into runs of equal keys, cut each run into
    // chunks of at most MAXD, keep the first DEPTH chunks. A chunk is written in the
    // cycle just past its last sample (the cumulative sample count).
    task automatic build_model();
        int n;
        int s;
        int e;
        int len;
        int chunk;
        int pos;
        exp_ent.delete();
        exp_cyc.delete();
        exp_play.delete();
        n   = rec_seq.size();
        s   = 0;
        pos = 0;
        while (s < n && exp_ent.size() < DEPTH) begin
            e = s;
            while (e < n && rec_seq[e] == rec_seq[s]) e++;
            len = e - s;
            while (len > 0 && exp_ent.size() < DEPTH) begin
                chunk = (len > MAXD) ? MAXD : len;
                pos  += chunk;
                len  -= chunk;
                exp_ent.push_back(pack_entry(4'(rec_seq[s]), 26'(chunk)));
                exp_cyc.push_back(pos);
                for (int k = 0; k < chunk; k++) exp_play.push_back(4'(rec_seq[s]));
            end
            s = e;
        end
    endtask

    // Records rec_seq (first sample in the rec_start cycle), then pulses stop.
    task automatic do_record(input bit with_play);
        int n;
        int base;
        int end_cyc;
        build_model();
        n       = rec_seq.size();
        end_cyc = exp_cyc[exp_cyc.size()-1];
        waddr.delete();
        wdat.delete();
        wcyc.delete();
        rec_start  = 1'b1;
        play_start = with_play;
        keys       = 4'(rec_seq[0]);
        base       = cyc_cnt;
        @(negedge clk);
        chk("rec_c0_mode", mode, MODE_IDLE);
        step();
        rec_start  = 1'b0;
        play_start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c < n) keys = 4'(rec_seq[c]);
            else begin
                keys = 4'($urandom);
                stop = 1'b1;
            end
            @(negedge clk);
            chk("rec_mode", mode, (c <= end_cyc) ? 64'd1 : 64'd0);
            chk("rec_keys_out", keys_out, keys);
            if (c == 1) chk("rec_len_cleared", take_len, 0);
            step();
        end
        stop = 1'b0;
        @(negedge clk);
        chk("rec_end_mode", mode, MODE_IDLE);
        chk("rec_take_len", take_len, exp_ent.size());
        chk("rec_nwrites", waddr.size(), exp_ent.size());
        for (int k = 0; k < exp_ent.size(); k++) begin
            if (k < waddr.size()) begin
                chk("wr_addr", waddr[k], k);
                chk("wr_data", wdat[k], exp_ent[k]);
                chk("wr_cycle", wcyc[k] - base, exp_cyc[k]);
            end
        end
        step();
    endtask

    // Replays the stored take and checks keys_out cycle by cycle against the model.
    task automatic do_play();
        play_start = 1'b1;
        keys       = 4'($urandom);
        @(negedge clk);
        chk("play_c0_mode", mode, MODE_IDLE);
        step();
        play_start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            keys = 4'($urandom);
            @(negedge clk);
            chk("play_pre_mode", mode, MODE_PLAY);
            chk("play_pre_keys", keys_out, keys);
            chk("play_pre_addr", ram_addr, c - 1);
            chk("play_pre_wren", ram_wren, 0);
            step();
        end
        for (int i = 0; i < exp_play.size(); i++) begin
            keys = 4'($urandom);
            @(negedge clk);
            chk("play_keys", keys_out, exp_play[i]);
            chk("play_mode", mode, MODE_PLAY);
            step();
        end
        keys = 4'($urandom);
        @(negedge clk);
        chk("play_end_mode", mode, MODE_IDLE);
        chk("play_end_keys", keys_out, keys);
        chk("play_end_len", take_len, exp_ent.size());
        step();
    endtask

    initial begin
        reset      = 1'b1;
        rec_start  = 1'b0;
        play_start = 1'b0;
        stop       = 1'b0;
        keys       = 4'hA;
        step();
        step();
        @(negedge clk);
        chk("rst_mode", mode, MODE_IDLE);
        chk("rst_take_len", take_len, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_keys_out", keys_out, 4'hA);
        step();
        reset = 1'b0;

        // play_start with no take is ignored.
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            keys = 4'($urandom);
            @(negedge clk);
            chk("empty_play_mode", mode, MODE_IDLE);
            chk("empty_play_addr", ram_addr, 0);
            chk("empty_play_keys", keys_out, keys);
            step();
        end

        // Basic take: 0001 x5, 0011 x3, stop; replayed twice.
        rec_seq = '{1, 1, 1, 1, 1, 3, 3, 3};
        do_record(1'b0);
        do_play();
        do_play();

        // Long hold split at MAX_DUR.
        rec_seq.delete();
        for (int i = 0; i < 25; i++) rec_seq.push_back(4);
        do_record(1'b0);
        do_play();

        // RAM full: keys change every cycle for 40 cycles.
        rec_seq.delete();
        for (int i = 0; i < 40; i++) rec_seq.push_back(i % 16);
        do_record(1'b0);
        do_play();

        // rec_start wins over simultaneous play_start.
        rec_seq = '{7, 7, 2, 2, 2, 9};
        do_record(1'b1);
        do_play();

        // Randomised takes built from runs of random length.
        for (int t = 0; t < 6; t++) begin
            int n;
            int k;
            int rl;
            rec_seq.delete();
            n = $urandom_range(1, 60);
            while (rec_seq.size() < n) begin
                k  = $urandom_range(0, 15);
                rl = $urandom_range(1, 24);
                for (int j = 0; j < rl && rec_seq.size() < n; j++) rec_seq.push_back(k);
            end
            do_record(1'b0);
            do_play();
        end

        // Reset in the middle of playback discards the take.
        rec_seq = '{5, 5, 5, 6, 6, 6, 6, 7};
        do_record(1'b0);
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("midplay_mode", mode, MODE_PLAY);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        keys  = 4'h9;
        @(negedge clk);
        chk("rstplay_mode", mode, MODE_IDLE);
        chk("rstplay_take_len", take_len, 0);
        chk("rstplay_keys_out", keys_out, 4'h9);
        chk("rstplay_wren", ram_wren, 0);
        step();
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        @(negedge clk);
        chk("rstplay_replay_mode", mode, MODE_IDLE);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keytake_sequencer.md
# keytake_sequencer

Record/playback sequencer for the synthesizer's key-take memory. Captures the 4-bit key bus as run-length events (key value + hold duration) into an external single-port synchronous RAM, then replays them cycle-exact onto the voice input. It sits between the key debouncer and the tone generators and owns the RAM's address, write enable and data.

## Interface
- KEY_W, 4, key bus width
- DUR_W, 26, duration field width
- ADDR_W, 5, RAM address width
- DEPTH, 30, usable RAM entries (addresses 0..DEPTH-1)
- MAX_DUR, 49_999_999, longest single event in cycles (1 s at 50 MHz)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- rec_start  in  1  single-cycle pulse: begin new take
- play_start  in  1  single-cycle pulse: replay stored take
- stop  in  1  single-cycle pulse: end recording or playback
- keys  in  KEY_W  live key bus
- keys_out  out  KEY_W  to voices: replayed keys in PLAY, else live keys
- mode  out  2  00 idle, 01 recording, 10 playing
- take_len  out  ADDR_W+1  entries in stored take (0 = none)
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  KEY_W+DUR_W  {keys, dur}
- ram_rdata  in  KEY_W+DUR_W  RAM q; valid one cycle after ram_addr

## Operation
- States: IDLE, REC, PFETCH, PWAIT, PLAY.
- IDLE: mode 00, ram_wren 0. rec_start -> REC (wins over simultaneous play_start). play_start with take_len != 0 -> PFETCH; with take_len 0 ignored. stop ignored.
- REC entry: cur_keys <= keys, dur <= 1, wptr <= 0, take_len <= 0.
- REC per cycle: commit if keys != cur_keys, dur == MAX_DUR, or stop. Commit = ram_wren 1, ram_addr wptr, ram_wdata {cur_keys, dur}; wptr and take_len +1; cur_keys <= keys; dur <= 1. Otherwise dur +1.
- REC exit to IDLE: after commit caused by stop, or commit at wptr == DEPTH-1 (RAM full; later keys dropped). rec_start/play_start ignored in REC.
- PFETCH: ram_addr 0 -> PWAIT. PWAIT: load entry 0 into play_keys/hold, ram_addr 1 (prefetch) -> PLAY.
- PLAY: keys_out = play_keys. Cycle after each load, ram_rdata latched into next_entry. hold counts down; when hold == 1 and rptr+1 < take_len, load next_entry, rptr +1, issue prefetch of rptr+2 (address wraps harmlessly; data unused past take_len). When hold == 1 on last entry, or stop -> IDLE.
- Duration field 0 never written; MAX_DUR split produces consecutive entries with equal keys.
- take_len preserved across playbacks; cleared only by reset or rec_start.

## Timing
- Reset: state IDLE, mode 00, take_len 0, ram_wren 0, ram_addr 0, ram_wdata 0, play_keys 0; keys_out follows keys combinationally.
- mode is registered from state; 01 from cycle after rec_start until cycle after final commit.
- Commit write happens in the same cycle the key change is seen on keys; new event counts that cycle as dur 1.
- Playback: first replayed key appears on keys_out 3 cycles after play_start sampled (PFETCH, PWAIT, PLAY). Each entry drives keys_out for exactly dur cycles, no gaps between entries.
- Reset mid-REC/PLAY: aborts immediately, take discarded (take_len 0).

## Structure
- Shared package: state enum, mode encodings (MODE_IDLE/REC/PLAY), MAX_DUR default, entry field widths and {keys,dur} packing helper.
- One sub-module: keytake_event_counter (dur counter with saturate-at-MAX_DUR flag), reused by the hold-down counter in PLAY.

## Test plan
- Reset, rec_start, keys 0001 for 5 cycles, 0011 for 3, stop -> writes {0001,5} @0, {0011,3} @1 (stop commit), take_len 2, mode back 00.
- play_start after above -> keys_out 0001 for 5 cycles starting 3 cycles later, then 0011 for 3, then live keys, mode 10->00.
- MAX_DUR=10, hold keys 0100 for 25 cycles, stop -> entries {0100,10},{0100,10},{0100,5}; playback gives 25 contiguous cycles of 0100.
- Change keys every cycle for 40 cycles -> 30 writes, exit at wptr 29, take_len 30, no write with ram_addr >= 30.
- rec_start and play_start same cycle in IDLE -> REC; play_start with take_len 0 -> stays IDLE, no RAM read.
- Reset asserted mid-PLAY -> next cycle IDLE, mode 00, take_len 0, keys_out = live keys.
